apb_timer_event_core: RTL

Timer core that sits at the DUT end of the timer subsystem's side-band signals: consumes stoptimer_i, event_lo_i and event_hi_i, and produces busy_o plus per-half interrupts.
Two WIDTH-bit counters (lo/hi) run independently or cascaded as one 2*WIDTH counter.
Each counter ticks on HCLK or on synchronised external event edges.
A simple single-cycle register port (driven by the APB bridge) configures it.

---
 rtl/apb_timer_event_core.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/apb_timer_event_core.sv
// Dual WIDTH-bit timer core: lo/hi counters, independent or cascaded, ticking on
// HCLK or on synchronised external event edges, configured via a single-cycle register port.
module apb_timer_event_core #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             cfg_wr_i,
  input  logic             cfg_rd_i,
  input  logic [2:0]       cfg_addr_i,
  input  logic [WIDTH-1:0] cfg_wdata_i,
  output logic [WIDTH-1:0] cfg_rdata_o,
  input  logic             stoptimer_i,
  input  logic             event_lo_i,
  input  logic             event_hi_i,
  output logic             busy_o,
  output logic             irq_lo_o,
  output logic             irq_hi_o
);

  localparam logic [2:0] ADDR_CTRL_LO = 3'd0;
  localparam logic [2:0] ADDR_CTRL_HI = 3'd1;
  localparam logic [2:0] ADDR_CNT_LO  = 3'd2;
  localparam logic [2:0] ADDR_CNT_HI  = 3'd3;
  localparam logic [2:0] ADDR_CMP_LO  = 3'd4;
  localparam logic [2:0] ADDR_CMP_HI  = 3'd5;
  localparam logic [2:0] ADDR_STATUS  = 3'd6;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_lo, sync_hi;
  logic                   prev_lo, prev_hi;
  logic                   evt_tick_lo, evt_tick_hi;

  logic             en_lo, evt_lo, os_lo, cascade;
  logic             en_hi, evt_hi, os_hi;
  logic [WIDTH-1:0] cnt_lo, cnt_hi, cmp_lo, cmp_hi;
  logic [1:0]       status;

  logic wr_ctrl_lo, wr_ctrl_hi, wr_cnt_lo, wr_cnt_hi, wr_cmp_lo, wr_cmp_hi, wr_status;
  logic tick_lo, tick_hi, match_lo, match_hi, os_clr_lo, os_clr_hi;
  logic [1:0]       status_clr;
  logic [WIDTH-1:0] rd_mux;

  // Event synchronisers and rising-edge detectors run regardless of enable/stop
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sync_lo <= '0;
      sync_hi <= '0;
      prev_lo <= 1'b0;
      prev_hi <= 1'b0;
    end else begin
      sync_lo <= {sync_lo[SYNC_STAGES-2:0], event_lo_i};
      sync_hi <= {sync_hi[SYNC_STAGES-2:0], event_hi_i};
      prev_lo <= sync_lo[SYNC_STAGES-1];
      prev_hi <= sync_hi[SYNC_STAGES-1];
    end
  end

  assign evt_tick_lo = sync_lo[SYNC_STAGES-1] & ~prev_lo;
  assign evt_tick_hi = sync_hi[SYNC_STAGES-1] & ~prev_hi;

  assign wr_ctrl_lo = cfg_wr_i && (cfg_addr_i == ADDR_CTRL_LO);
  assign wr_ctrl_hi = cfg_wr_i && (cfg_addr_i == ADDR_CTRL_HI);
  assign wr_cnt_lo  = cfg_wr_i && (cfg_addr_i == ADDR_CNT_LO);
  assign wr_cnt_hi  = cfg_wr_i && (cfg_addr_i == ADDR_CNT_HI);
  assign wr_cmp_lo  = cfg_wr_i && (cfg_addr_i == ADDR_CMP_LO);
  assign wr_cmp_hi  = cfg_wr_i && (cfg_addr_i == ADDR_CMP_HI);
  assign wr_status  = cfg_wr_i && (cfg_addr_i == ADDR_STATUS);

  // A CPU write to a counter swallows that cycle's tick, so no match is evaluated either
  assign tick_lo  = en_lo & ~stoptimer_i & (evt_lo ? evt_tick_lo : 1'b1);
  assign match_lo = tick_lo & ~wr_cnt_lo & (cnt_lo == cmp_lo);
  assign tick_hi  = cascade ? match_lo
                            : (en_hi & ~stoptimer_i & (evt_hi ? evt_tick_hi : 1'b1));
  assign match_hi = tick_hi & ~wr_cnt_hi & (cnt_hi == cmp_hi);

  // In cascade the lo one-shot only fires at the full double-width terminal count
  assign os_clr_lo = os_lo & match_lo & (~cascade | match_hi);
  assign os_clr_hi = os_hi & match_hi & ~cascade;

  assign status_clr = wr_status ? cfg_wdata_i[1:0] : 2'b00;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      en_lo   <= 1'b0;
      evt_lo  <= 1'b0;
      os_lo   <= 1'b0;
      cascade <= 1'b0;
      en_hi   <= 1'b0;
      evt_hi  <= 1'b0;
      os_hi   <= 1'b0;
    end else begin
      if (wr_ctrl_lo) begin
        en_lo   <= cfg_wdata_i[0];
        evt_lo  <= cfg_wdata_i[1];
        os_lo   <= cfg_wdata_i[2];
        cascade <= cfg_wdata_i[3];
      end else if (os_clr_lo) begin
        en_lo <= 1'b0;
      end
      if (wr_ctrl_hi) begin
        en_hi  <= cfg_wdata_i[0];
        evt_hi <= cfg_wdata_i[1];
        os_hi  <= cfg_wdata_i[2];
      end else if (os_clr_hi) begin
        en_hi <= 1'b0;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cnt_lo <= '0;
      cnt_hi <= '0;
    end else begin
      if (wr_cnt_lo)
        cnt_lo <= cfg_wdata_i;
      else if (tick_lo)
        cnt_lo <= match_lo ? '0 : cnt_lo + ONE;
      if (wr_cnt_hi)
        cnt_hi <= cfg_wdata_i;
      else if (tick_hi)
        cnt_hi <= match_hi ? '0 : cnt_hi + ONE;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cmp_lo <= '1;
      cmp_hi <= '1;
    end else begin
      if (wr_cmp_lo)
        cmp_lo <= cfg_wdata_i;
      if (wr_cmp_hi)
        cmp_hi <= cfg_wdata_i;
    end
  end

  // Hardware set is OR-ed in after the clear so a coincident match survives W1C
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      status   <= 2'b00;
      irq_lo_o <= 1'b0;
      irq_hi_o <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      status   <= (status & ~status_clr) | {match_hi, match_lo};
      irq_lo_o <= match_lo;
      irq_hi_o <= match_hi;
      busy_o   <= (en_lo | (en_hi & ~cascade)) & ~stoptimer_i;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (cfg_addr_i)
      ADDR_CTRL_LO: rd_mux[3:0] = {cascade, os_lo, evt_lo, en_lo};
      ADDR_CTRL_HI: rd_mux[2:0] = {os_hi, evt_hi, en_hi};
      ADDR_CNT_LO:  rd_mux      = cnt_lo;
      ADDR_CNT_HI:  rd_mux      = cnt_hi;
      ADDR_CMP_LO:  rd_mux      = cmp_lo;
      ADDR_CMP_HI:  rd_mux      = cmp_hi;
      ADDR_STATUS:  rd_mux[1:0] = status;
      default:      rd_mux      = '0;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)
      cfg_rdata_o <= '0;
    else
      cfg_rdata_o <= cfg_rd_i ? rd_mux : '0;
  end

endmodule
